// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule stage.
// Takes one 512-bit block and streams W0..W(ROUNDS-1) on a valid/ready port.
// Optional feature macro: MSG_SCHED_ABORT_EN adds an `abort` input that
// drops an in-flight block back to IDLE.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge.
// A consumer may change ready freely. Neither valid nor ready depends
// combinationally on the other side of the same port.
`timescale 1ns/1ps

module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_word,
    output logic [5:0]   w_index,
    output logic         w_last
`ifdef MSG_SCHED_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_RUN   = 1'b1;
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic        state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_new;
    logic        abort_req;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef MSG_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Outputs come from registered state only; no input-to-output path.
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        w_valid  = (state_q == ST_RUN);
        w_word   = win_q[0];
        w_index  = idx_q;
        w_last   = (state_q == ST_RUN) && (idx_q == LAST_IDX);
    end

    // Next state: load in IDLE, shift window and append recurrence word in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        // W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t), window base at t.
        w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = in_block[511 - 32 * i -: 32];
                    end
                    idx_d   = 6'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Abort wins over a same-edge word accept.
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (w_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i + 1];
                        end
                        win_d[15] = w_new;
                        idx_d     = idx_q + 6'd1;
                    end
                end
            end
        endcase
    end

    // State, index and window registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: reference schedule computed from the
// textbook recurrence over a full 64-entry array, scoreboard queue of
// expected words, randomized blocks and backpressure.
`timescale 1ns/1ps

module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_word;
    logic [5:0]   w_index;
    logic         w_last;
`ifdef MSG_SCHED_ABORT_EN
    logic         abort;
`endif

    int total;
    int bad;
    int cyc;

    logic [31:0] exp_q [$];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_block (in_block),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_index  (w_index),
        .w_last   (w_last)
`ifdef MSG_SCHED_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic compute_ref(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                ref_w[t] = blk[511 - 32 * t -: 32];
            end else begin
                ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                         + ref_w[t-7]
                         + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                         + ref_w[t-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    // Wait (bounded) for in_ready, present the block for one accept edge.
    task automatic load(input logic [511:0] blk);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("load_ready", {31'd0, in_ready}, 32'd1);
        compute_ref(blk);
        exp_q.delete();
        for (int t = 0; t < ROUNDS; t++) exp_q.push_back(ref_w[t]);
        in_block = blk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Consume the word stream. mode 0: ready always high; mode 1: random.
    // stall_idx: index held with 5 stall cycles. abort_idx: index at which
    // abort is pulsed together with an accept (-1 = never).
    task automatic drain(input int mode, input int stall_idx, input int abort_idx);
        int t;
        int stalls;
        int cycles;
        bit done;
        bit abort_now;
        logic [31:0] exp_word;
        t = 0; stalls = 0; cycles = 0; done = 1'b0;
        while (!done) begin
            if (cycles >= 2000) begin
                check("drain_timeout", 32'd0, 32'd1);
                exp_q.delete();
                done = 1'b1;
            end else begin
                if (mode == 0) w_ready = 1'b1;
                else if (t == stall_idx && stalls < 5) begin
                    w_ready = 1'b0;
                    stalls++;
                end else w_ready = 1'($urandom_range(0, 1));
                abort_now = (t == abort_idx);
`ifdef MSG_SCHED_ABORT_EN
                if (abort_now) begin
                    w_ready = 1'b1;
                    abort   = 1'b1;
                end
`endif
                exp_word = (exp_q.size() > 0) ? exp_q[0] : 32'hdead_beef;
                check("w_valid", {31'd0, w_valid}, 32'd1);
                check("w_index", {26'd0, w_index}, 32'(t));
                check("w_word", w_word, exp_word);
                check("w_last", {31'd0, w_last}, {31'd0, (t == ROUNDS - 1)});
                check("in_ready_run", {31'd0, in_ready}, 32'd0);
                got_w[t] = w_word;
                @(negedge clk);
`ifdef MSG_SCHED_ABORT_EN
                abort = 1'b0;
`endif
                if (abort_now) begin
                    exp_q.delete();
                    done = 1'b1;
                    check("abort_idle_valid", {31'd0, w_valid}, 32'd0);
                    check("abort_idle_ready", {31'd0, in_ready}, 32'd1);
                end else if (w_ready) begin
                    void'(exp_q.pop_front());
                    if (t == ROUNDS - 1) begin
                        done = 1'b1;
                        check("end_in_ready", {31'd0, in_ready}, 32'd1);
                        check("end_w_valid", {31'd0, w_valid}, 32'd0);
                    end
                    t++;
                end
                cycles++;
            end
        end
        w_ready = 1'b0;
    endtask

    task automatic run_block(input logic [511:0] blk, input int mode, input int stall_idx);
        load(blk);
        drain(mode, stall_idx, -1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_w_word"}, w_word, 32'd0);
        check({tag, "_w_index"}, {26'd0, w_index}, 32'd0);
        check({tag, "_w_last"}, {31'd0, w_last}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [511:0] abc_blk;
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    int           t0;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        w_ready = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        abc_blk = '0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst_init");
        rst = 1'b0;
        @(negedge clk);

        // "abc" block, full throughput, plus known words
        run_block(abc_blk, 0, -1);
        check("abc_w0", got_w[0], 32'h6162_6380);
        check("abc_w15", got_w[15], 32'h0000_0018);
        check("abc_w16", got_w[16], 32'h6162_6380);
        check("abc_w17", got_w[17], 32'h000F_0000);

        // all-zero block
        run_block('0, 0, -1);
        check("zero_w63", got_w[63], 32'd0);

        // backpressure on "abc", 5-cycle stall on index 15
        run_block(abc_blk, 1, 15);
        check("bp_w17", got_w[17], 32'h000F_0000);

        // random blocks with random backpressure
        for (int k = 0; k < 4; k++) begin
            run_block(rand_block(), 1, $urandom_range(0, ROUNDS - 1));
        end

        // back-to-back: in_valid held high with the next block during RUN
        blk_a = rand_block();
        blk_b = rand_block();
        load(blk_a);
        in_valid = 1'b1;
        in_block = blk_b;
        w_ready  = 1'b1;
        t0 = cyc;
        for (int t = 0; t < ROUNDS; t++) begin
            check("btb_a_index", {26'd0, w_index}, 32'(t));
            check("btb_a_word", w_word, exp_q.size() > 0 ? exp_q[0] : 32'hdead_beef);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(negedge clk);
        end
        check("btb_idle_ready", {31'd0, in_ready}, 32'd1);
        compute_ref(blk_b);
        for (int t = 0; t < ROUNDS; t++) exp_q.push_back(ref_w[t]);
        @(negedge clk);
        in_valid = 1'b0;
        check("btb_b_gap", 32'(cyc - t0), 32'(ROUNDS + 1));
        drain(0, -1, -1);

`ifdef MSG_SCHED_ABORT_EN
        // abort while index 20 is being accepted, then a clean block
        load(abc_blk);
        drain(0, -1, 20);
        run_block(rand_block(), 1, -1);
`endif

        // asynchronous reset in the middle of a block
        load(rand_block());
        w_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        w_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_w_valid", {31'd0, w_valid}, 32'd0);
        end
        w_ready = 1'b0;

        // block after reset starts cleanly
        run_block(abc_blk, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule stage for the miner datapath. It accepts one 512-bit message block per transaction and streams the expanded words W0..W(ROUNDS-1), one 32-bit word per accepted beat. The stream goes to the downstream compression-round stage. It sits between the block/nonce assembly logic upstream and the compression core downstream.

## Interface
- `ROUNDS`, 64, number of schedule words emitted per block; legal range 17..64.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream block valid.
- `in_ready`  out  1  block accepted when `in_valid && in_ready`.
- `in_block`  in  512  message block; `[511:480]` = W0 … `[31:0]` = W15 (big-endian word order).
- `w_valid`  out  1  schedule word valid.
- `w_ready`  in  1  downstream accepts the word when `w_valid && w_ready`.
- `w_word`  out  32  current schedule word Wt.
- `w_index`  out  6  t of current word.
- `w_last`  out  1  high with `w_valid` when `w_index == ROUNDS-1`.
- `abort`  in  1  present only with `MSG_SCHED_ABORT_EN`.

## Operation
- State machine states:
  - IDLE: `in_ready`=1, `w_valid`=0.
  - RUN: `in_ready`=0, `w_valid`=1.
- Load:
  - In IDLE, `in_valid` is sampled.
  - On accept, the 16-word window `win[0..15]` is loaded with W0..W15, the index is set to 0, and the block moves to RUN.
- Output: `w_word` = `win[0]`; `w_index` = the index counter.
- Advance (on `w_valid && w_ready`, not last):
  - `win[i]` <= `win[i+1]` for i = 0..14.
  - `win[15]` <= σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]`, with mod 2^32 wrap-around addition.
  - The index increments by 1.
- Functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Last word: on accept with `w_last`=1, the block returns to IDLE. Window contents are don't-care afterwards.
- Stall: while `w_valid && !w_ready`, `w_word`, `w_index`, `w_last` and all internal state hold stable.
- `in_valid` is ignored in RUN; upstream must hold its block until `in_ready`.

## Timing
- Reset values (asynchronous, take effect immediately on `rst` high):
  - state = IDLE.
  - `in_ready`=1, `w_valid`=0, `w_word`=0, `w_index`=0, `w_last`=0.
  - window = 0.
- Latency: W0 is valid on the cycle after the `in_valid && in_ready` edge.
- Throughput:
  - With `w_ready` held high, one word per cycle.
  - A block occupies ROUNDS cycles of RUN plus 1 IDLE cycle, i.e. ROUNDS+1 cycles per block.
- Words W0..W15 come straight from the load. W16 onward comes from the recurrence, with no extra latency; the recurrence is a single-cycle combinational adder tree on the window.
- Reset mid-block: the block drops to IDLE immediately. No partial words are emitted after reset release.
- `w_last` is combinationally derived from the registered index and state only. It has no input-to-output combinational path.
- `in_ready` is derived from state only.

## Configuration
- `MSG_SCHED_ABORT_EN` defined:
  - Adds input `abort`.
  - `abort`=1 on a clock edge in RUN forces IDLE on that edge; no further words are emitted. Abort takes priority over a simultaneous word accept.
  - In IDLE, `abort` is ignored and does not block a load.
  - This is used when upstream changes the job (new work).
- `MSG_SCHED_ABORT_EN` undefined:
  - The port is absent.
  - Every accepted block runs to `w_last`; only `rst` terminates early.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs go to reset values without waiting for `clk`; `in_ready`=1.
- **"abc" block:**
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018, `w_ready`=1.
  - Required response: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - Required response: 64 words on consecutive cycles, with `w_last` only at index 63.
  - Required response: compare all words against a software reference.
- **All-zero block:** → all 64 words 0x00000000; `in_ready` returns to 1 exactly one cycle after `w_last` is accepted.
- **Backpressure:**
  - Stimulus: "abc" block with `w_ready` toggled pseudo-randomly, including a 5-cycle stall on index 15.
  - Required response: identical word sequence; outputs are stable during stalls; no word is skipped or duplicated.
- **Back-to-back blocks:** `in_valid` is held high with a new block during RUN → it is accepted only in IDLE, and the second block's W0 appears ROUNDS+1 cycles after the first block's W0 (with `w_ready`=1).
- **`MSG_SCHED_ABORT_EN`:** pulse `abort` at index 20 while the word is being accepted → no index 21 is output; IDLE follows; the next block starts cleanly at W0.
